vga_timing_controller: RTL and testbench

Sequences the horizontal and vertical pixel counters of the VGA output path and decodes them into sync, blanking and coordinate signals. Defaults are 1024x768@70Hz: H total 1328, V total 806, 75 MHz pixel rate, negative syncs. It sits between the pixel-clock domain enable and the pixel generator / DAC output stage.

---
 rtl/vga_timing_pkg.sv | 16 +
 rtl/vga_axis_timer.sv | 52 +++++
 rtl/vga_timing_controller.sv | 63 ++++++
 tb/tb_vga_timing_controller.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: axis state type, default 1024x768@70 mode constants and total-length helper
package vga_timing_pkg;
    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} axis_state_t;
    localparam int DEF_CNT_WIDTH = 11;
    localparam int DEF_H_ACTIVE = 1024;
    localparam int DEF_H_FRONT = 24;
    localparam int DEF_H_SYNC = 136;
    localparam int DEF_H_BACK = 144;
    localparam int DEF_V_ACTIVE = 768;
    localparam int DEF_V_FRONT = 3;
    localparam int DEF_V_SYNC = 6;
    localparam int DEF_V_BACK = 29;
    function automatic int axis_total(input int active, input int front, input int sync_len, input int back);
        return active + front + sync_len + back;
    endfunction
endpackage

// File: rtl/vga_axis_timer.sv
// vga_axis_timer: one display axis, counting through ACTIVE/FRONT/SYNC/BACK with a registered sync
module vga_axis_timer
    import vga_timing_pkg::*;
#(
    parameter int CNT_WIDTH = 11,
    parameter int ACTIVE_LEN = 1024,
    parameter int FRONT_LEN = 24,
    parameter int SYNC_LEN = 136,
    parameter int BACK_LEN = 144,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 advance,
    output logic [CNT_WIDTH-1:0] count,
    output axis_state_t          state,
    output logic                 sync,
    output logic                 wrap
);
    localparam int TOTAL = axis_total(ACTIVE_LEN, FRONT_LEN, SYNC_LEN, BACK_LEN);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] FRONT_START = CNT_WIDTH'(ACTIVE_LEN);
    localparam logic [CNT_WIDTH-1:0] SYNC_START = CNT_WIDTH'(ACTIVE_LEN + FRONT_LEN);
    localparam logic [CNT_WIDTH-1:0] BACK_START = CNT_WIDTH'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN);
    logic [CNT_WIDTH-1:0] count_nxt;
    axis_state_t state_nxt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= LAST;
            state <= BACK;
            sync <= ~SYNC_POL;
        end else begin
            count <= count_nxt;
            state <= state_nxt;
            sync <= (state_nxt == SYNC) ? SYNC_POL : ~SYNC_POL;
        end
    end
    always_comb begin
        count_nxt = advance ? (wrap ? '0 : count + 1'b1) : count;
        state_nxt = state;
        case (state)
            ACTIVE: if (count_nxt == FRONT_START) state_nxt = FRONT;
            FRONT: if (count_nxt == SYNC_START) state_nxt = SYNC;
            SYNC: if (count_nxt == BACK_START) state_nxt = BACK;
            BACK: if (count_nxt == '0) state_nxt = ACTIVE;
            default: state_nxt = BACK;
        endcase
    end
    always_comb begin
        wrap = (count == LAST);
    end
endmodule

// File: rtl/vga_timing_controller.sv
// vga_timing_controller: H/V pixel counters decoded into registered sync, blanking and line/frame pulses
module vga_timing_controller
    import vga_timing_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT = DEF_H_FRONT,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BACK = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT = DEF_V_FRONT,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BACK = DEF_V_BACK,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0
) (
    input  logic                 control_clock,
    input  logic                 control_reset_n,
    input  logic                 timing_enable,
    input  logic                 pixel_enable,
    output logic [CNT_WIDTH-1:0] pixel_x,
    output logic [CNT_WIDTH-1:0] pixel_y,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 display_enable,
    output logic                 line_start,
    output logic                 frame_start
);
    localparam logic [CNT_WIDTH-1:0] H_LAST_ACT = CNT_WIDTH'(H_ACTIVE - 1);
    localparam logic [CNT_WIDTH-1:0] V_LAST_ACT = CNT_WIDTH'(V_ACTIVE - 1);
    axis_state_t h_state, v_state;
    logic h_adv, h_wrap, v_adv, v_wrap, h_act_nxt, v_act_nxt;
    assign h_adv = timing_enable & pixel_enable;
    assign v_adv = h_adv & h_wrap;
    vga_axis_timer #(
        .CNT_WIDTH(CNT_WIDTH), .ACTIVE_LEN(H_ACTIVE), .FRONT_LEN(H_FRONT),
        .SYNC_LEN(H_SYNC), .BACK_LEN(H_BACK), .SYNC_POL(H_SYNC_POL)
    ) u_h (
        .clk(control_clock), .rst_n(control_reset_n), .advance(h_adv),
        .count(pixel_x), .state(h_state), .sync(hsync), .wrap(h_wrap)
    );
    vga_axis_timer #(
        .CNT_WIDTH(CNT_WIDTH), .ACTIVE_LEN(V_ACTIVE), .FRONT_LEN(V_FRONT),
        .SYNC_LEN(V_SYNC), .BACK_LEN(V_BACK), .SYNC_POL(V_SYNC_POL)
    ) u_v (
        .clk(control_clock), .rst_n(control_reset_n), .advance(v_adv),
        .count(pixel_y), .state(v_state), .sync(vsync), .wrap(v_wrap)
    );
    // Predict next-cycle ACTIVE membership so display_enable is a flop aligned with the counts
    assign h_act_nxt = h_adv ? (h_wrap | ((h_state == ACTIVE) & (pixel_x != H_LAST_ACT))) : (h_state == ACTIVE);
    assign v_act_nxt = v_adv ? (v_wrap | ((v_state == ACTIVE) & (pixel_y != V_LAST_ACT))) : (v_state == ACTIVE);
    always_ff @(posedge control_clock or negedge control_reset_n) begin
        if (!control_reset_n) begin
            display_enable <= 1'b0;
            line_start <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            display_enable <= h_act_nxt & v_act_nxt;
            line_start <= v_adv;
            frame_start <= v_adv & v_wrap;
        end
    end
endmodule

// File: tb/tb_vga_timing_controller.sv
// tb_vga_timing_controller: directed vector table on the default mode plus a tiny mode for full-frame runs
module tb_vga_timing_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic te = 1'b0, pe = 1'b0, s_te = 1'b0, s_pe = 1'b0;
    logic [10:0] x, y, s_x, s_y;
    logic hs, vs, de, ls, fs, s_hs, s_vs, s_de, s_ls, s_fs;
    int checks = 0;
    int failures = 0;

    typedef struct {
        bit te; bit pe; int n;
        int x; int y; bit hs; bit vs; bit de; bit ls; bit fs;
    } vec_t;
    vec_t vecs[13];

    always #5 clk = ~clk;

    vga_timing_controller dut (
        .control_clock(clk), .control_reset_n(rst_n), .timing_enable(te), .pixel_enable(pe),
        .pixel_x(x), .pixel_y(y), .hsync(hs), .vsync(vs), .display_enable(de),
        .line_start(ls), .frame_start(fs)
    );

    // Tiny mode: H 8/2/3/3 (total 16), V 6/1/2/3 (total 12), positive syncs
    vga_timing_controller #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
    ) dut_s (
        .control_clock(clk), .control_reset_n(rst_n), .timing_enable(s_te), .pixel_enable(s_pe),
        .pixel_x(s_x), .pixel_y(s_y), .hsync(s_hs), .vsync(s_vs), .display_enable(s_de),
        .line_start(s_ls), .frame_start(s_fs)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string n, input int ex, input int ey, input int ehs,
                             input int evs, input int ede, input int els, input int efs);
        check({n, ".x"}, int'(x), ex);
        check({n, ".y"}, int'(y), ey);
        check({n, ".hsync"}, int'(hs), ehs);
        check({n, ".vsync"}, int'(vs), evs);
        check({n, ".de"}, int'(de), ede);
        check({n, ".line_start"}, int'(ls), els);
        check({n, ".frame_start"}, int'(fs), efs);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int mx, my, err, fs_cnt, vs_cnt, hs_cnt, hold_err;
        vecs[0]  = '{1, 0, 3,    1327, 805, 1, 1, 0, 0, 0};
        vecs[1]  = '{0, 1, 3,    1327, 805, 1, 1, 0, 0, 0};
        vecs[2]  = '{1, 1, 1,    0,    0,   1, 1, 1, 1, 1};
        vecs[3]  = '{1, 1, 1,    1,    0,   1, 1, 1, 0, 0};
        vecs[4]  = '{1, 1, 1022, 1023, 0,   1, 1, 1, 0, 0};
        vecs[5]  = '{1, 1, 1,    1024, 0,   1, 1, 0, 0, 0};
        vecs[6]  = '{1, 1, 23,   1047, 0,   1, 1, 0, 0, 0};
        vecs[7]  = '{1, 1, 1,    1048, 0,   0, 1, 0, 0, 0};
        vecs[8]  = '{1, 1, 135,  1183, 0,   0, 1, 0, 0, 0};
        vecs[9]  = '{1, 1, 1,    1184, 0,   1, 1, 0, 0, 0};
        vecs[10] = '{1, 1, 143,  1327, 0,   1, 1, 0, 0, 0};
        vecs[11] = '{1, 1, 1,    0,    1,   1, 1, 1, 1, 0};
        vecs[12] = '{1, 0, 5,    0,    1,   1, 1, 1, 0, 0};

        repeat (3) step();
        check_all("reset", 1327, 805, 1, 1, 0, 0, 0);
        check("reset.small_x", int'(s_x), 15);
        check("reset.small_y", int'(s_y), 11);
        check("reset.small_hsync", int'(s_hs), 0);
        check("reset.small_vsync", int'(s_vs), 0);
        rst_n = 1'b1;

        // Three full frames of the tiny mode against a behavioural position model
        s_te = 1'b1; s_pe = 1'b1;
        mx = 15; my = 11; fs_cnt = 0; vs_cnt = 0; hs_cnt = 0;
        for (int f = 0; f < 3; f++) begin
            err = 0;
            for (int i = 0; i < 192; i++) begin
                step();
                if (mx == 15) begin
                    mx = 0;
                    my = (my == 11) ? 0 : my + 1;
                end else mx++;
                if (int'(s_x) != mx || int'(s_y) != my) err++;
                if (int'(s_hs) != int'(mx >= 10 && mx <= 12)) err++;
                if (int'(s_vs) != int'(my >= 7 && my <= 8)) err++;
                if (int'(s_de) != int'(mx < 8 && my < 6)) err++;
                if (int'(s_ls) != int'(mx == 0)) err++;
                if (int'(s_fs) != int'(mx == 0 && my == 0)) err++;
                fs_cnt += int'(s_fs);
                vs_cnt += int'(s_vs);
                hs_cnt += int'(s_hs);
            end
            check($sformatf("small_frame%0d_errors", f), err, 0);
        end
        check("small_frame_start_count", fs_cnt, 3);
        check("small_vsync_cycles", vs_cnt, 96);
        check("small_hsync_cycles", hs_cnt, 108);
        s_te = 1'b0;

        for (int i = 0; i < 13; i++) begin
            te = vecs[i].te;
            pe = vecs[i].pe;
            repeat (vecs[i].n) step();
            check_all($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, int'(vecs[i].hs), int'(vecs[i].vs),
                      int'(vecs[i].de), int'(vecs[i].ls), int'(vecs[i].fs));
        end

        // pixel_enable toggling across a line wrap
        pe = 1'b1;
        repeat (1326) step();
        check("pre_toggle.x", int'(x), 1326);
        pe = 1'b1; step();
        check("toggle0.x", int'(x), 1327);
        check("toggle0.ls", int'(ls), 0);
        pe = 1'b0; step();
        check("toggle1.x", int'(x), 1327);
        pe = 1'b1; step();
        check("toggle2.x", int'(x), 0);
        check("toggle2.y", int'(y), 2);
        check("toggle2.ls", int'(ls), 1);
        check("toggle2.fs", int'(fs), 0);
        pe = 1'b0; step();
        check("toggle3.x", int'(x), 0);
        check("toggle3.ls", int'(ls), 0);
        pe = 1'b1; step();
        check("toggle4.x", int'(x), 1);
        check("toggle4.ls", int'(ls), 0);

        // timing_enable dropped for 10 cycles at x=500
        repeat (499) step();
        check("pause.x", int'(x), 500);
        check("pause.y", int'(y), 2);
        te = 1'b0;
        hold_err = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (x != 11'd500 || y != 11'd2 || ls || fs || !de || !hs || !vs) hold_err++;
        end
        check("pause_hold_errors", hold_err, 0);
        te = 1'b1;
        step();
        check("resume.x", int'(x), 501);

        // Asynchronous reset mid-line at (700,2)
        repeat (199) step();
        check("pre_reset.x", int'(x), 700);
        #2 rst_n = 1'b0;
        #1 check_all("async_reset", 1327, 805, 1, 1, 0, 0, 0);
        @(negedge clk);
        check_all("reset_held", 1327, 805, 1, 1, 0, 0, 0);
        rst_n = 1'b1;
        step();
        check_all("restart", 0, 0, 1, 1, 1, 1, 1);
        step();
        check_all("restart_next", 1, 0, 1, 1, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
